// File: rtl/lcd_hex_driver.sv
`default_nettype none
// ============================================================================
// Module      : lcd_hex_driver
// Description : Renders PC / source index / data nibbles as ASCII hex on an
//               HD44780-compatible 16x2 LCD over an 8-bit parallel bus.
//               Optional macro LCD_CHANGE_REFRESH_EN: refresh only on change.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_hex_driver #(
    parameter int POWERUP_CYCLES     = 750000,
    parameter int EN_PULSE_CYCLES    = 12,
    parameter int CMD_DELAY_CYCLES   = 2000,
    parameter int CLEAR_DELAY_CYCLES = 82000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] ox1,
    input  logic [3:0] ox2,
    input  logic [3:0] ox3,
    input  logic [3:0] ox4,
    input  logic [3:0] ox5,
    input  logic [3:0] ox6,
    input  logic [3:0] ox7,
    input  logic [3:0] ox8,
    input  logic [3:0] oy,
    input  logic [3:0] oz1,
    input  logic [3:0] oz2,
    input  logic [3:0] oz3,
    input  logic [3:0] oz4,
    input  logic [3:0] oz5,
    input  logic [3:0] oz6,
    input  logic [3:0] oz7,
    input  logic [3:0] oz8,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_on,
    output logic       init_done,
    output logic       frame_done
);

    localparam logic [2:0] c_ST_POWERUP = 3'd0;
    localparam logic [2:0] c_ST_INIT    = 3'd1;
    localparam logic [2:0] c_ST_SNAP    = 3'd2;
    localparam logic [2:0] c_ST_L1      = 3'd3;
    localparam logic [2:0] c_ST_L2      = 3'd4;
    localparam logic [2:0] c_ST_DONE    = 3'd5;
`ifdef LCD_CHANGE_REFRESH_EN
    localparam logic [2:0] c_ST_WAIT    = 3'd6;
`endif

    localparam logic [1:0] c_PH_SETUP = 2'd0;
    localparam logic [1:0] c_PH_PULSE = 2'd1;
    localparam logic [1:0] c_PH_HOLD  = 2'd2;

    localparam logic [31:0] c_PWR_LAST = 32'(POWERUP_CYCLES - 1);
    localparam logic [31:0] c_EN_LAST  = 32'(EN_PULSE_CYCLES - 1);
    localparam logic [31:0] c_CMD_LAST = 32'(CMD_DELAY_CYCLES - 1);
    localparam logic [31:0] c_CLR_LAST = 32'(CLEAR_DELAY_CYCLES - 1);

    logic [2:0]  r_state;
    logic [1:0]  r_phase;
    logic [31:0] r_cnt;
    logic [4:0]  r_idx;
    logic [7:0]  r_lcd_data;
    logic        r_lcd_rs;
    logic        r_lcd_en;
    logic        r_lcd_on;
    logic        r_init_done;
    logic        r_frame_done;
    logic [31:0] r_pc;
    logic [3:0]  r_src;
    logic [31:0] r_dat;

    logic [31:0] w_live_pc;
    logic [31:0] w_live_dat;
    logic [31:0] w_hold_last;

    assign w_live_pc  = {ox8, ox7, ox6, ox5, ox4, ox3, ox2, ox1};
    assign w_live_dat = {oz8, oz7, oz6, oz5, oz4, oz3, oz2, oz1};

    // Clear-display needs a much longer settle time than every other byte
    assign w_hold_last = (r_lcd_data == 8'h01 && !r_lcd_rs) ? c_CLR_LAST : c_CMD_LAST;

`ifdef LCD_CHANGE_REFRESH_EN
    logic w_changed;
    assign w_changed = ({w_live_pc, oy, w_live_dat} != {r_pc, r_src, r_dat});
`endif

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        hex_ascii = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [3:0] digit_of(input logic [31:0] word, input logic [4:0] idx);
        case (idx)
            5'd4:    digit_of = word[31:28];
            5'd5:    digit_of = word[27:24];
            5'd6:    digit_of = word[23:20];
            5'd7:    digit_of = word[19:16];
            5'd8:    digit_of = word[15:12];
            5'd9:    digit_of = word[11:8];
            5'd10:   digit_of = word[7:4];
            default: digit_of = word[3:0];
        endcase
    endfunction

    // idx 1..16 are the character cells; idx 0 is the DDRAM address command
    function automatic logic [7:0] line_char(input logic line2, input logic [4:0] idx,
                                             input logic [31:0] pc, input logic [3:0] src,
                                             input logic [31:0] dat);
        case (idx)
            5'd1:    line_char = line2 ? 8'h44 : 8'h50;
            5'd2:    line_char = line2 ? hex_ascii(src) : 8'h43;
            5'd3:    line_char = 8'h3D;
            5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11:
                     line_char = hex_ascii(digit_of(line2 ? dat : pc, idx));
            default: line_char = 8'h20;
        endcase
    endfunction

    function automatic logic [7:0] init_cmd(input logic [4:0] idx);
        case (idx)
            5'd0:    init_cmd = 8'h38;
            5'd1:    init_cmd = 8'h0C;
            5'd2:    init_cmd = 8'h01;
            default: init_cmd = 8'h06;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_POWERUP;
            r_phase      <= c_PH_SETUP;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_lcd_data   <= 8'h00;
            r_lcd_rs     <= 1'b0;
            r_lcd_en     <= 1'b0;
            r_lcd_on     <= 1'b0;
            r_init_done  <= 1'b0;
            r_frame_done <= 1'b0;
            r_pc         <= '0;
            r_src        <= '0;
            r_dat        <= '0;
        end else begin
            r_lcd_on <= 1'b1;
            case (r_state)
                c_ST_POWERUP: begin
                    if (r_cnt == c_PWR_LAST) begin
                        r_cnt      <= '0;
                        r_idx      <= '0;
                        r_state    <= c_ST_INIT;
                        r_lcd_rs   <= 1'b0;
                        r_lcd_data <= init_cmd(5'd0);
                        r_phase    <= c_PH_SETUP;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                c_ST_SNAP: begin
                    r_pc       <= w_live_pc;
                    r_src      <= oy;
                    r_dat      <= w_live_dat;
                    r_state    <= c_ST_L1;
                    r_idx      <= '0;
                    r_cnt      <= '0;
                    r_lcd_rs   <= 1'b0;
                    r_lcd_data <= 8'h80;
                    r_phase    <= c_PH_SETUP;
                end
                c_ST_DONE: begin
                    r_frame_done <= 1'b0;
`ifdef LCD_CHANGE_REFRESH_EN
                    r_state      <= c_ST_WAIT;
`else
                    r_state      <= c_ST_SNAP;
`endif
                end
`ifdef LCD_CHANGE_REFRESH_EN
                c_ST_WAIT: begin
                    if (w_changed) begin
                        r_state <= c_ST_SNAP;
                    end
                end
`endif
                c_ST_INIT, c_ST_L1, c_ST_L2: begin
                    case (r_phase)
                        c_PH_SETUP: begin
                            r_lcd_en <= 1'b1;
                            r_cnt    <= '0;
                            r_phase  <= c_PH_PULSE;
                        end
                        c_PH_PULSE: begin
                            if (r_cnt == c_EN_LAST) begin
                                r_lcd_en <= 1'b0;
                                r_cnt    <= '0;
                                r_phase  <= c_PH_HOLD;
                            end else begin
                                r_cnt <= r_cnt + 32'd1;
                            end
                        end
                        default: begin
                            if (r_cnt == w_hold_last) begin
                                r_cnt   <= '0;
                                r_phase <= c_PH_SETUP;
                                case (r_state)
                                    c_ST_INIT: begin
                                        if (r_idx == 5'd3) begin
                                            r_init_done <= 1'b1;
                                            r_state     <= c_ST_SNAP;
                                        end else begin
                                            r_idx      <= r_idx + 5'd1;
                                            r_lcd_data <= init_cmd(r_idx + 5'd1);
                                        end
                                    end
                                    c_ST_L1: begin
                                        if (r_idx == 5'd16) begin
                                            r_state    <= c_ST_L2;
                                            r_idx      <= '0;
                                            r_lcd_rs   <= 1'b0;
                                            r_lcd_data <= 8'hC0;
                                        end else begin
                                            r_idx      <= r_idx + 5'd1;
                                            r_lcd_rs   <= 1'b1;
                                            r_lcd_data <= line_char(1'b0, r_idx + 5'd1, r_pc, r_src, r_dat);
                                        end
                                    end
                                    default: begin
                                        if (r_idx == 5'd16) begin
                                            r_state      <= c_ST_DONE;
                                            r_frame_done <= 1'b1;
                                        end else begin
                                            r_idx      <= r_idx + 5'd1;
                                            r_lcd_rs   <= 1'b1;
                                            r_lcd_data <= line_char(1'b1, r_idx + 5'd1, r_pc, r_src, r_dat);
                                        end
                                    end
                                endcase
                            end else begin
                                r_cnt <= r_cnt + 32'd1;
                            end
                        end
                    endcase
                end
                default: begin
                    r_state <= c_ST_POWERUP;
                end
            endcase
        end
    end

    assign lcd_data   = r_lcd_data;
    assign lcd_rs     = r_lcd_rs;
    assign lcd_rw     = 1'b0;
    assign lcd_en     = r_lcd_en;
    assign lcd_on     = r_lcd_on;
    assign init_done  = r_init_done;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_lcd_hex_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_hex_driver
// Description : Self-checking bench for lcd_hex_driver; captures every byte
//               strobed on lcd_en and compares against a string-built model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_hex_driver;

    localparam int PWR = 10;
    localparam int EN  = 2;
    localparam int CMD = 3;
    localparam int CLR = 8;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic [31:0] pc_in  = '0;
    logic [3:0]  src_in = '0;
    logic [31:0] dat_in = '0;

    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic       lcd_on;
    logic       init_done;
    logic       frame_done;

    lcd_hex_driver #(
        .POWERUP_CYCLES    (PWR),
        .EN_PULSE_CYCLES   (EN),
        .CMD_DELAY_CYCLES  (CMD),
        .CLEAR_DELAY_CYCLES(CLR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ox1       (pc_in[3:0]),
        .ox2       (pc_in[7:4]),
        .ox3       (pc_in[11:8]),
        .ox4       (pc_in[15:12]),
        .ox5       (pc_in[19:16]),
        .ox6       (pc_in[23:20]),
        .ox7       (pc_in[27:24]),
        .ox8       (pc_in[31:28]),
        .oy        (src_in),
        .oz1       (dat_in[3:0]),
        .oz2       (dat_in[7:4]),
        .oz3       (dat_in[11:8]),
        .oz4       (dat_in[15:12]),
        .oz5       (dat_in[19:16]),
        .oz6       (dat_in[23:20]),
        .oz7       (dat_in[27:24]),
        .oz8       (dat_in[31:28]),
        .lcd_data  (lcd_data),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en),
        .lcd_on    (lcd_on),
        .init_done (init_done),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int         cyc = 0;
    logic       prev_en = 1'b0;
    logic       prev_id = 1'b0;
    logic [8:0] cap_b[$];
    int         cap_rise[$];
    int         cap_fall[$];
    int         fd_cyc[$];
    int         initdone_cyc = -1;
    int         fd_seen_cyc = 0;

    logic [8:0] exp_frame[34];
    logic [7:0] hex_tab[16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                                8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};

    // Bus monitor: one sample per cycle, on the inactive edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (lcd_en && !prev_en) begin
            cap_b.push_back({lcd_rs, lcd_data});
            cap_rise.push_back(cyc);
        end
        if (!lcd_en && prev_en) cap_fall.push_back(cyc);
        if (frame_done) fd_cyc.push_back(cyc);
        if (init_done && !prev_id) initdone_cyc = cyc;
        prev_en = lcd_en;
        prev_id = init_done;
    end

    function automatic string hex_str(input logic [31:0] v, input int nd);
        string s;
        string digs;
        logic [31:0] sh;
        digs = "0123456789ABCDEF";
        s = "";
        for (int i = nd - 1; i >= 0; i--) begin
            sh = v >> (4 * i);
            s = {s, digs.substr(int'(sh[3:0]), int'(sh[3:0]))};
        end
        return s;
    endfunction

    task automatic build_frame(input logic [31:0] pc, input logic [3:0] src, input logic [31:0] dat);
        string l1;
        string l2;
        l1 = {"PC=", hex_str(pc, 8), "     "};
        l2 = {"D", hex_str({28'h0, src}, 1), "=", hex_str(dat, 8), "     "};
        exp_frame[0]  = 9'h080;
        exp_frame[17] = 9'h0C0;
        for (int i = 0; i < 16; i++) begin
            exp_frame[1 + i]  = {1'b1, l1[i]};
            exp_frame[18 + i] = {1'b1, l2[i]};
        end
    endtask

    task automatic wait_bytes(input int n, input string name);
        int guard;
        guard = 0;
        while (cap_b.size() < n && guard < 3000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        n_cmp++;
        if (cap_b.size() < n) begin
            n_err++;
            $display("FAIL %s: timeout, captured %0d bytes, required %0d", name, cap_b.size(), n);
        end
    endtask

    task automatic wait_fd(input string name);
        int guard;
        guard = 0;
        while (guard < 3000) begin
            @(negedge clk);
            #1;
            if (frame_done) break;
            guard++;
        end
        n_cmp++;
        if (!frame_done) begin
            n_err++;
            $display("FAIL %s: frame_done timeout, got %b required 1", name, frame_done);
        end
        fd_seen_cyc = cyc;
    endtask

    task automatic check_frame(input int base, input logic [31:0] pc, input logic [3:0] src,
                               input logic [31:0] dat, input string name);
        int bad;
        build_frame(pc, src, dat);
        wait_bytes(base + 34, name);
        if (cap_b.size() >= base + 34) begin
            bad = -1;
            for (int i = 0; i < 34; i++) begin
                if (bad < 0 && cap_b[base + i] !== exp_frame[i]) bad = i;
            end
            n_cmp++;
            if (bad >= 0) begin
                n_err++;
                $display("FAIL %s: byte %0d got %h required %h", name, bad,
                         cap_b[base + bad], exp_frame[bad]);
            end
        end
    endtask

    task automatic run_frame(input logic [31:0] pc, input logic [3:0] src,
                             input logic [31:0] dat, input string name);
        int base;
        pc_in  = pc;
        src_in = src;
        dat_in = dat;
        base   = cap_b.size();
        check_frame(base, pc, src, dat, name);
        wait_fd(name);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        pc_in  = 32'h0040001C;
        src_in = 4'h2;
        dat_in = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (lcd_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_data: got %h required 00", lcd_data);
        end
        n_cmp++;
        if ({lcd_rs, lcd_rw, lcd_en, lcd_on, init_done, frame_done} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {lcd_rs, lcd_rw, lcd_en, lcd_on, init_done, frame_done});
        end
    endtask

    task automatic test_init();
        int r0;
        int guard;
        logic [7:0] cmds[4];
        int gap;
        cmds = '{8'h38, 8'h0C, 8'h01, 8'h06};
        cap_b.delete();
        cap_rise.delete();
        cap_fall.delete();
        fd_cyc.delete();
        initdone_cyc = -1;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        r0 = cyc;
        @(negedge clk);
        #1;
        n_cmp++;
        if (lcd_on !== 1'b1) begin
            n_err++;
            $display("FAIL lcd_on: got %b required 1", lcd_on);
        end
        wait_bytes(4, "init_bytes");
        guard = 0;
        while (!init_done && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (cap_b.size() >= 4 && cap_fall.size() >= 4) begin
            n_cmp++;
            if (cap_rise[0] - r0 != PWR + 1) begin
                n_err++;
                $display("FAIL first_en_delay: got %0d required %0d", cap_rise[0] - r0, PWR + 1);
            end
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (cap_b[i] !== {1'b0, cmds[i]}) begin
                    n_err++;
                    $display("FAIL init_cmd%0d: got %h required %h", i, cap_b[i], {1'b0, cmds[i]});
                end
                n_cmp++;
                if (cap_fall[i] - cap_rise[i] != EN) begin
                    n_err++;
                    $display("FAIL en_width%0d: got %0d required %0d", i, cap_fall[i] - cap_rise[i], EN);
                end
            end
            for (int i = 0; i < 3; i++) begin
                gap = ((cmds[i] == 8'h01) ? CLR : CMD) + 1;
                n_cmp++;
                if (cap_rise[i + 1] - cap_fall[i] != gap) begin
                    n_err++;
                    $display("FAIL init_gap%0d: got %0d required %0d", i, cap_rise[i + 1] - cap_fall[i], gap);
                end
            end
            n_cmp++;
            if (initdone_cyc - cap_fall[3] != CMD) begin
                n_err++;
                $display("FAIL init_done_time: got %0d required %0d", initdone_cyc - cap_fall[3], CMD);
            end
        end
    endtask

    task automatic test_content();
        check_frame(4, 32'h0040001C, 4'h2, 32'hDEADBEEF, "content");
        wait_fd("content_fd");
        n_cmp++;
        if (fd_cyc.size() != 1) begin
            n_err++;
            $display("FAIL fd_count: got %0d required 1", fd_cyc.size());
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL fd_width: got %b required 0", frame_done);
        end
    endtask

    task automatic test_snapshot();
        int base;
        pc_in  = 32'h00400020;
        src_in = 4'h2;
        dat_in = 32'hDEADBEEF;
        base   = cap_b.size();
        wait_bytes(base + 2, "snap_start");
        dat_in = 32'h12345678;
        check_frame(base, 32'h00400020, 4'h2, 32'hDEADBEEF, "snap_current");
        wait_fd("snap_fd1");
        base = cap_b.size();
        check_frame(base, 32'h00400020, 4'h2, 32'h12345678, "snap_next");
        wait_fd("snap_fd2");
    endtask

    task automatic test_hex_sweep();
        int base;
        logic [31:0] v;
        for (int k = 0; k < 16; k++) begin
            v      = {8{4'(k)}};
            pc_in  = v;
            src_in = 4'(k);
            dat_in = v;
            base   = cap_b.size();
            check_frame(base, v, 4'(k), v, "hex_sweep");
            if (cap_b.size() >= base + 34) begin
                n_cmp++;
                if (cap_b[base + 4][7:0] !== hex_tab[k] || cap_b[base + 21][7:0] !== hex_tab[k]) begin
                    n_err++;
                    $display("FAIL hex_digit%0d: got %h/%h required %h", k,
                             cap_b[base + 4][7:0], cap_b[base + 21][7:0], hex_tab[k]);
                end
            end
            wait_fd("hex_sweep_fd");
        end
    endtask

    task automatic test_random();
        logic [31:0] pc;
        logic [3:0]  src;
        logic [31:0] dat;
        for (int i = 0; i < 5; i++) begin
            pc  = $urandom;
            src = 4'($urandom_range(0, 15));
            dat = $urandom;
            if (pc == pc_in && src == src_in && dat == dat_in) pc = pc ^ 32'h1;
            run_frame(pc, src, dat, "random");
        end
    endtask

    task automatic test_refresh_mode();
`ifdef LCD_CHANGE_REFRESH_EN
        int n0;
        int n;
        int base;
        n0 = cap_b.size();
        repeat (500) @(negedge clk);
        #1;
        n_cmp++;
        if (cap_b.size() != n0) begin
            n_err++;
            $display("FAIL idle_pulses: got %0d required 0", cap_b.size() - n0);
        end
        dat_in[3:0] = dat_in[3:0] ^ 4'h1;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            #1;
            n++;
            if (lcd_data == 8'h80 && !lcd_rs) break;
        end
        n_cmp++;
        if (n > 2) begin
            n_err++;
            $display("FAIL change_latency: got %0d required <=2", n);
        end
        base = cap_b.size();
        check_frame(base, pc_in, src_in, dat_in, "change_frame");
        wait_fd("change_fd");
`else
        int d;
        d = fd_seen_cyc;
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({lcd_rs, lcd_data} !== 9'h080 || cyc - d != 2) begin
            n_err++;
            $display("FAIL next_frame_start: got %h at +%0d required 080 at +2", {lcd_rs, lcd_data}, cyc - d);
        end
        wait_fd("b2b_fd");
`endif
    endtask

    task automatic test_reset_mid_write();
        int guard;
        int r0;
        pc_in = pc_in ^ 32'h1;
        guard = 0;
        while (!lcd_en && guard < 500) begin
            @(negedge clk);
            #1;
            guard++;
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({lcd_en, lcd_on, init_done} !== 3'b000) begin
            n_err++;
            $display("FAIL mid_reset: got %b required 000", {lcd_en, lcd_on, init_done});
        end
        cap_b.delete();
        cap_rise.delete();
        cap_fall.delete();
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        r0 = cyc;
        wait_bytes(1, "restart");
        if (cap_b.size() >= 1) begin
            n_cmp++;
            if (cap_b[0] !== 9'h038 || cap_rise[0] - r0 != PWR + 1) begin
                n_err++;
                $display("FAIL restart_cmd: got %h at %0d required 038 at %0d",
                         cap_b[0], cap_rise[0] - r0, PWR + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_content();
        test_snapshot();
        test_hex_sweep();
        test_random();
        test_refresh_mode();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_hex_driver.md
Name: lcd_hex_driver

Overview:
- Downstream consumer of the LCD nibble selector.
- Takes the 17 display nibbles (ox1..ox8 = PC, oy = source index, oz1..oz8 = selected data), converts each to ASCII hex, and drives an HD44780-compatible 16x2 character LCD over an 8-bit parallel bus.
- Runs the power-up/init sequence once, then refreshes both lines continuously from a per-frame snapshot of the inputs.

Parameters:
- POWERUP_CYCLES, 750000: clk cycles idle after reset before the first command (15 ms at 50 MHz).
- EN_PULSE_CYCLES, 12: cycles lcd_en is held high per byte.
- CMD_DELAY_CYCLES, 2000: cycles lcd_en is held low after each byte (40 us).
- CLEAR_DELAY_CYCLES, 82000: low-hold length used after the 0x01 clear command instead of CMD_DELAY_CYCLES.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ox1..ox8  input  4 each  PC nibbles; ox1 = LSB nibble, ox8 = MSB nibble.
- oy  input  4  source index.
- oz1..oz8  input  4 each  data nibbles; oz1 = LSB nibble.
- lcd_data  output  8  LCD data bus.
- lcd_rs  output  1  0 = command, 1 = character.
- lcd_rw  output  1  always 0 (write only).
- lcd_en  output  1  LCD enable strobe.
- lcd_on  output  1  LCD power enable.
- init_done  output  1  high once the init sequence completes.
- frame_done  output  1  one-cycle pulse after the last byte of each frame.

Behaviour:
- Reset (asynchronous, immediate, including mid-byte): lcd_data=0x00, lcd_rs=0, lcd_rw=0, lcd_en=0, lcd_on=0, init_done=0, frame_done=0, all counters 0, FSM in POWERUP.
- lcd_on goes to 1 on the first clk edge after reset release and stays 1.
- Byte write (shared by all states), total 1+EN_PULSE_CYCLES+HOLD cycles:
  - SETUP: 1 cycle; drive lcd_rs and lcd_data, lcd_en=0.
  - PULSE: lcd_en=1 for EN_PULSE_CYCLES cycles.
  - HOLD: lcd_en=0 for HOLD cycles, where HOLD = CLEAR_DELAY_CYCLES for command 0x01 and CMD_DELAY_CYCLES otherwise.
  - lcd_rs and lcd_data remain stable through PULSE and HOLD.
- FSM states:
  - POWERUP: wait POWERUP_CYCLES, then go to INIT.
  - INIT: write commands 0x38, 0x0C, 0x01, 0x06 in that order with rs=0. After the last one, init_done=1 (sticky until reset); go to SNAP.
  - SNAP: 1 cycle; latch all 17 input nibbles into a shadow register; go to L1.
  - L1: write command 0x80, then 16 characters with rs=1.
  - L2: write command 0xC0, then 16 characters with rs=1.
  - DONE: frame_done=1 for 1 cycle; go to SNAP.
- Line content:
  - Line 1: 'P','C','=', hex(ox8)..hex(ox1), then 5 spaces (0x20).
  - Line 2: 'D', hex(oy), '=', hex(oz8)..hex(oz1), then 5 spaces.
- Hex mapping: nibble 0-9 -> 0x30-0x39; A-F -> 0x41-0x46 (uppercase).
- Frame: 34 bytes = 34*(1+EN_PULSE_CYCLES+CMD_DELAY_CYCLES) cycles, plus 1 SNAP cycle and 1 DONE cycle.
- Input changes during a frame are ignored; only the SNAP value is displayed.
- No busy-flag polling; timing is purely counter-based.

Optional Feature:
- Macro: LCD_CHANGE_REFRESH_EN.
- Defined: after DONE the FSM goes to WAIT instead of SNAP. WAIT compares the live inputs against the shadow register every cycle and goes to SNAP on the first cycle any nibble differs. lcd_en stays 0 while in WAIT.
- Undefined: no WAIT state; frames repeat back-to-back.

Test Plan:
All scenarios use POWERUP_CYCLES=10, EN_PULSE_CYCLES=2, CMD_DELAY_CYCLES=3, CLEAR_DELAY_CYCLES=8.
- Init: release rst_n -> first lcd_en rise 11 cycles later. Captured bytes with rs=0 are 0x38, 0x0C, 0x01, 0x06. Low-hold after 0x01 is 8 cycles, after the others 3 cycles. init_done rises after the 0x06 hold.
- Content: PC=0x0040001C, oy=2, oz=0xDEADBEEF.
  - Line 1 bytes: 0x80, "PC=0040001C", 5x0x20.
  - Line 2 bytes: 0xC0, "D2=DEADBEEF", 5x0x20.
  - frame_done pulses once.
- Snapshot: change oz to 0x12345678 during line 1 -> current frame line 2 still "DEADBEEF"; next frame shows "12345678".
- Hex sweep: over 16 frames set every nibble to k, k=0..F -> every digit byte equals the table value (e.g. k=0xA gives 0x41).
- Reset mid-write: drop rst_n while lcd_en=1 -> lcd_en, lcd_on, init_done go 0 in the same cycle. After release, the sequence restarts from POWERUP with 0x38.
- LCD_CHANGE_REFRESH_EN:
  - Defined: inputs stable -> zero lcd_en pulses after the first frame for 500 cycles. Toggle oz1 -> a new frame starts within 2 cycles and shows the new digit.
  - Undefined: the second frame's 0x80 follows frame_done by 2 cycles.
